// File: rtl/control_sequencer.sv
// Hardwired T-state controller for the DataPath: FETCH0..FETCH3 then T3..T6 per opcode class; Moore strobes.
// Latency FETCH0->FETCH0: ALU/imm 7, MUL/DIV 8, NOP 4 cycles plus memory wait; FETCH2 stalls on mem_ready.
module control_sequencer #(
  parameter int NREG        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic [31:0]     IR,
  input  logic            mem_ready,
  input  logic            Stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIout,
  output logic            LOout,
  output logic            MDRout,
  output logic            Cout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic            Zin_low,
  output logic            Zin_high,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [3:0]      operation,
  output logic            Run,
  output logic            fault
);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [4:0] OPC_ADDI = 5'b01000;
  localparam logic [4:0] OPC_ANDI = 5'b01001;
  localparam logic [4:0] OPC_ORI  = 5'b01010;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NEG = 4'b1010;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  localparam int             CW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  logic       is_alu3;
  logic       is_imm;
  logic       is_unary;
  logic       is_muldiv;
  logic       is_halt;
  logic       is_exec;
  logic [3:0] alu_op;

  always_comb begin
    is_alu3   = (opcode[4:3] == 2'b00);
    is_imm    = (opcode == OPC_ADDI) || (opcode == OPC_ANDI) || (opcode == OPC_ORI);
    is_unary  = (opcode == OPC_NEG) || (opcode == OPC_NOT);
    is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);
    is_halt   = (opcode == OPC_HALT);
    is_exec   = is_alu3 || is_imm || is_unary || is_muldiv;

    alu_op = ALU_ADD;
    case (opcode)
      OPC_ADDI: alu_op = ALU_ADD;
      OPC_ANDI: alu_op = ALU_AND;
      OPC_ORI:  alu_op = ALU_OR;
      OPC_MUL:  alu_op = ALU_MUL;
      OPC_DIV:  alu_op = ALU_DIV;
      OPC_NEG:  alu_op = ALU_NEG;
      OPC_NOT:  alu_op = ALU_NOT;
      default:  if (is_alu3) alu_op = {1'b0, opcode[2:0]};
    endcase
  end

  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    logic [NREG-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

  // Instruction boundary: the only point where Stop is honoured.
  state_t end_state;
  assign end_state = Stop ? S_HALTED : S_FETCH0;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state    <= S_RESET;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH0;
        S_FETCH0: state <= S_FETCH1;
        S_FETCH1: begin
          state    <= S_FETCH2;
          wait_cnt <= '0;
        end
        S_FETCH2: begin
          if (mem_ready) begin
            state <= S_FETCH3;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt == WAIT_LAST) state <= S_FAULT;
          end
        end
        S_FETCH3: begin
          if (is_halt)      state <= S_HALTED;
          else if (is_exec) state <= S_T3;
          else              state <= end_state;
        end
        S_T3:     state <= S_T4;
        S_T4:     state <= S_T5;
        S_T5:     state <= is_muldiv ? S_T6 : end_state;
        S_T6:     state <= end_state;
        S_HALTED: state <= S_HALTED;
        S_FAULT:  state <= S_FAULT;
        default:  state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Zin_low   = 1'b0;
    Zin_high  = 1'b0;
    Rout      = '0;
    Rin       = '0;
    operation = 4'b0000;
    Run       = 1'b0;
    fault     = 1'b0;

    case (state)
      S_FETCH0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
      end
      S_FETCH1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      S_FETCH2: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_FETCH3: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout = reg_sel(rb);
        Yin  = 1'b1;
      end
      // Immediates take the B operand from the constant driver instead of a register.
      S_T4: begin
        operation = alu_op;
        Zin_low   = 1'b1;
        Zin_high  = is_muldiv;
        if (is_imm)        Cout = 1'b1;
        else if (is_unary) Rout = reg_sel(rb);
        else               Rout = reg_sel(rc);
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = reg_sel(ra);
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase

    Run   = (state != S_RESET) && (state != S_HALTED) && (state != S_FAULT);
    fault = (state == S_FAULT);
  end

endmodule
